// File: rtl/cordic_result_fifo_if.sv
// Handshake bundle between a CORDIC result stage, the result FIFO and its consumer.
// The slave modport is the FIFO itself; the master modport is the surrounding logic.
interface cordic_result_fifo_if #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] Data_In;
   logic             Data_Ready;
   logic             IN_N_OUT;
   logic [WIDTH-1:0] Out_Data;
   logic             Out_Mode;
   logic             Out_Valid;
   logic             Out_Ready;
   logic [CW-1:0]    Count;
   logic             Full;
   logic             Empty;
   logic             Overflow;
   logic             Clr_Ovf;

   modport master (
      output Data_In, Data_Ready, IN_N_OUT, Out_Ready, Clr_Ovf,
      input  Out_Data, Out_Mode, Out_Valid, Count, Full, Empty, Overflow
   );

   modport slave (
      input  Data_In, Data_Ready, IN_N_OUT, Out_Ready, Clr_Ovf,
      output Out_Data, Out_Mode, Out_Valid, Count, Full, Empty, Overflow
   );
endinterface

// File: rtl/cordic_result_fifo.sv
// First-word fall-through FIFO capturing CORDIC results on the rising edge of
// Data_Ready. Each entry holds the result word plus its mode bit. A push into a
// full FIFO without a simultaneous pop is dropped and latches a sticky Overflow.
module cordic_result_fifo #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 8
) (
   input  logic                 CLK1,
   input  logic                 RST,
   cordic_result_fifo_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Entry layout: {mode, data}
   logic [WIDTH:0]    mem [DEPTH];
   logic [WIDTH:0]    head;

   logic [AW-1:0]     wr_ptr_reg;
   logic [AW-1:0]     rd_ptr_reg;
   logic [CW-1:0]     count_reg;
   logic [CW-1:0]     count_next;
   logic              rdy_d_reg;
   logic              overflow_reg;

   logic              push_evt;
   logic              push_ok;
   logic              pop;
   logic              drop;
   logic              full;
   logic              empty;

   // Status is decoded purely from the registered count, so Out_Ready never
   // reaches Full/Empty/Out_Valid combinationally.
   assign full  = (count_reg == CW'(DEPTH));
   assign empty = (count_reg == '0);

   // A held Data_Ready level only counts once: push on its rising edge.
   assign push_evt = bus.Data_Ready & ~rdy_d_reg;
   assign pop      = ~empty & bus.Out_Ready;
   // When full, a same-cycle pop frees the slot the push needs.
   assign push_ok  = push_evt & (~full | pop);
   assign drop     = push_evt & full & ~pop;

   // Next occupancy: net change of +1, -1 or 0.
   always_comb begin
      count_next = count_reg;
      case ({push_ok, pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   // Pointers, occupancy, edge detector and sticky overflow.
   always_ff @(posedge CLK1 or posedge RST) begin
      if (RST) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         rdy_d_reg    <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         rdy_d_reg <= bus.Data_Ready;
         count_reg <= count_next;
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop) begin
            overflow_reg <= 1'b1;
         end else if (bus.Clr_Ovf) begin
            overflow_reg <= 1'b0;
         end
      end
   end

   // Storage write; contents are not reset, only the pointers are.
   always_ff @(posedge CLK1) begin
      if (push_ok && !RST) begin
         mem[wr_ptr_reg] <= {bus.IN_N_OUT, bus.Data_In};
      end
   end

   // Fall-through read of the head entry; storage is not read when empty.
   assign head = empty ? '0 : mem[rd_ptr_reg];

   assign bus.Out_Data  = head[WIDTH-1:0];
   assign bus.Out_Mode  = head[WIDTH];
   assign bus.Out_Valid = ~empty;
   assign bus.Count     = count_reg;
   assign bus.Full      = full;
   assign bus.Empty     = empty;
   assign bus.Overflow  = overflow_reg;
endmodule

// File: tb/tb_cordic_result_fifo.sv
// Directed bench for cordic_result_fifo with a queue scoreboard of {mode, data}.
`timescale 1ns/1ps
module tb_cordic_result_fifo;
   localparam int WIDTH = 13;
   localparam int DEPTH = 8;

   logic clk;
   logic rst;

   cordic_result_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   cordic_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK1 (clk),
      .RST  (rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [WIDTH:0] sb_q [$];
   logic           model_prev_dr;
   logic           model_ovf;
   int             n_checks;
   int             n_bad;

   // One comparison: counted, and reported on mismatch.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check pop data before the edge, update the
   // model, let the edge happen, then check occupancy and flags after it.
   task automatic cycle(input logic dr, input logic [WIDTH-1:0] data, input logic mode,
                        input logic ordy, input logic clr);
      logic [WIDTH:0] exp_word;
      logic           popped;
      logic           dropped;
      bus.Data_Ready = dr;
      bus.Data_In    = data;
      bus.IN_N_OUT   = mode;
      bus.Out_Ready  = ordy;
      bus.Clr_Ovf    = clr;
      #1;
      check("valid_pre", 32'(bus.Out_Valid), 32'(sb_q.size() != 0));
      popped  = 1'b0;
      dropped = 1'b0;
      if (ordy && sb_q.size() != 0) begin
         exp_word = sb_q.pop_front();
         popped   = 1'b1;
         check("pop_data", 32'(bus.Out_Data), 32'(exp_word[WIDTH-1:0]));
         check("pop_mode", 32'(bus.Out_Mode), 32'(exp_word[WIDTH]));
      end
      if (dr && !model_prev_dr) begin
         if (sb_q.size() < DEPTH) sb_q.push_back({mode, data});
         else dropped = 1'b1;
      end
      if (dropped) model_ovf = 1'b1;
      else if (clr) model_ovf = 1'b0;
      model_prev_dr = dr;
      @(posedge clk);
      #1;
      $display("cyc t=%0t dr=%0b din=%0h m=%0b ordy=%0b clr=%0b pop=%0b drop=%0b cnt=%0d ovf=%0b",
               $time, dr, data, mode, ordy, clr, popped, dropped, bus.Count, bus.Overflow);
      check("count", 32'(bus.Count), 32'(sb_q.size()));
      check("overflow", 32'(bus.Overflow), 32'(model_ovf));
      check("empty", 32'(bus.Empty), 32'(sb_q.size() == 0));
      check("full", 32'(bus.Full), 32'(sb_q.size() == DEPTH));
   endtask

   task automatic pulse(input logic [WIDTH-1:0] data, input logic mode, input logic ordy);
      cycle(1'b1, data, mode, ordy, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int k = 0; k < 2 * DEPTH && sb_q.size() != 0; k++) begin
         cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      end
      check("drain_done", 32'(sb_q.size()), 32'd0);
      check("drain_empty", 32'(bus.Empty), 32'd1);
   endtask

   initial begin
      n_checks       = 0;
      n_bad          = 0;
      model_prev_dr  = 1'b0;
      model_ovf      = 1'b0;
      bus.Data_In    = '0;
      bus.Data_Ready = 1'b0;
      bus.IN_N_OUT   = 1'b0;
      bus.Out_Ready  = 1'b0;
      bus.Clr_Ovf    = 1'b0;
      rst            = 1'b1;
      #1;
      check("rst_count", 32'(bus.Count), 32'd0);
      check("rst_empty", 32'(bus.Empty), 32'd1);
      check("rst_full", 32'(bus.Full), 32'd0);
      check("rst_valid", 32'(bus.Out_Valid), 32'd0);
      check("rst_ovf", 32'(bus.Overflow), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single result with Data_Ready held for 4 cycles
      for (int i = 0; i < 4; i++) cycle(1'b1, 13'h0400, 1'b0, 1'b0, 1'b0);
      check("single_count", 32'(bus.Count), 32'd1);
      check("single_valid", 32'(bus.Out_Valid), 32'd1);
      check("single_data", 32'(bus.Out_Data), 32'h0400);
      check("single_mode", 32'(bus.Out_Mode), 32'd0);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      drain();

      // Fill with 1..9, ninth is dropped
      for (int i = 1; i <= 9; i++) pulse(WIDTH'(i), 1'b0, 1'b0);
      check("fill_count", 32'(bus.Count), 32'd8);
      check("fill_full", 32'(bus.Full), 32'd1);
      check("fill_ovf", 32'(bus.Overflow), 32'd1);
      check("fill_head", 32'(bus.Out_Data), 32'd1);
      drain();

      // Clear alone
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      check("clr_alone", 32'(bus.Overflow), 32'd0);

      // Full with simultaneous push and pop
      for (int i = 1; i <= 8; i++) pulse(WIDTH'(i), 1'b1, 1'b0);
      cycle(1'b1, 13'd9, 1'b1, 1'b1, 1'b0);
      check("pp_count", 32'(bus.Count), 32'd8);
      check("pp_ovf", 32'(bus.Overflow), 32'd0);
      check("pp_head", 32'(bus.Out_Data), 32'd2);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      drain();

      // Clear coincident with a drop: set wins
      for (int i = 1; i <= 8; i++) pulse(WIDTH'(16 + i), 1'b0, 1'b0);
      cycle(1'b1, 13'h1ff, 1'b0, 1'b0, 1'b1);
      check("clr_vs_drop", 32'(bus.Overflow), 32'd1);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
      check("clr_after", 32'(bus.Overflow), 32'd0);
      drain();

      // Reset mid-cycle with 5 entries, Data_Ready already high at release
      for (int i = 1; i <= 5; i++) pulse(WIDTH'(32 + i), 1'b0, 1'b0);
      check("pre_rst_count", 32'(bus.Count), 32'd5);
      bus.Data_Ready = 1'b1;
      bus.Data_In    = 13'h0abc;
      bus.IN_N_OUT   = 1'b1;
      #2;
      rst = 1'b1;
      #0.5;
      check("mid_rst_count", 32'(bus.Count), 32'd0);
      check("mid_rst_empty", 32'(bus.Empty), 32'd1);
      check("mid_rst_valid", 32'(bus.Out_Valid), 32'd0);
      #0.5;
      rst = 1'b0;
      sb_q.delete();
      model_prev_dr = 1'b0;
      model_ovf     = 1'b0;
      #0.5;
      check("post_rst_count", 32'(bus.Count), 32'd0);
      cycle(1'b1, 13'h0abc, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 13'h0abc, 1'b1, 1'b0, 1'b0);
      check("rst_release_push", 32'(bus.Count), 32'd1);
      check("rst_release_data", 32'(bus.Out_Data), 32'h0abc);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      drain();

      // Pointer wrap: 20 push/pop pairs with occupancy held at 2
      pulse(13'h100, 1'b0, 1'b0);
      pulse(13'h101, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         pulse(WIDTH'(13'h102 + i), logic'(i % 2), 1'b1);
      end
      drain();

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end
endmodule

// File: doc/cordic_result_fifo.md
CORDIC_RESULT_FIFO -- requirements
Module: cordic_result_fifo

Interface
REQ-001 Parameter WIDTH, default 13: data word width, matching the CORDIC Data_Out.
REQ-002 Parameter DEPTH, default 8: number of entries; SHALL be a power of two and at least 2.
REQ-003 Port CLK1  in  1: the single clock; all logic samples on its rising edge.
REQ-004 Port RST  in  1: reset, asynchronous and active-high.
REQ-005 Port Data_In  in  WIDTH: result word from the CORDIC stage's Data_Out.
REQ-006 Port Data_Ready  in  1: CORDIC result-valid level; it may stay high for several cycles.
REQ-007 Port IN_N_OUT  in  1: CORDIC mode bit; it is stored alongside each word.
REQ-008 Port Out_Data  out  WIDTH: word at the head of the FIFO.
REQ-009 Port Out_Mode  out  1: mode bit stored with the head word.
REQ-010 Port Out_Valid  out  1: head word is valid.
REQ-011 Port Out_Ready  in  1: consumer accepts the head word.
REQ-012 Port Count  out  log2(DEPTH)+1: current number of stored entries.
REQ-013 Port Full  out  1: Count equals DEPTH.
REQ-014 Port Empty  out  1: Count equals 0.
REQ-015 Port Overflow  out  1: sticky flag, set when a result is dropped.
REQ-016 Port Clr_Ovf  in  1: synchronous clear for Overflow.

Function
REQ-017 The block SHALL register Data_Ready into Rdy_d every cycle; a push event is Data_Ready=1 with Rdy_d=0 (rising edge only).
REQ-018 On a push event, the block SHALL capture {IN_N_OUT, Data_In} from that same cycle into the entry at wr_ptr.
REQ-019 A held Data_Ready level SHALL yield exactly one push; a new push requires Data_Ready to go 0 and then return to 1.
REQ-020 A pop occurs when Out_Valid=1 and Out_Ready=1 in the same cycle; rd_ptr then advances.
REQ-021 Out_Valid SHALL equal not Empty; Out_Data and Out_Mode SHALL always present the entry at rd_ptr (first-word fall-through).
REQ-022 Push-to-Out_Valid latency SHALL be 1 cycle: Out_Valid goes high on the edge after the push event, when the FIFO was empty.
REQ-023 wr_ptr and rd_ptr SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 with no extra logic.
REQ-024 Count update rules:
- push only: Count+1
- pop only: Count-1
- push and pop together: Count unchanged
- neither: Count unchanged
REQ-025 Push while Full without a pop: the word SHALL be dropped, pointers and Count SHALL be unchanged, and Overflow SHALL be set to 1 on the next edge.
REQ-026 Push while Full with a simultaneous pop: the push SHALL be accepted, Count SHALL stay DEPTH, and Overflow SHALL NOT be set.
REQ-027 Pop while Empty cannot occur, because Out_Valid=0; Out_Ready SHALL then be ignored.
REQ-028 Push while Empty with Out_Ready=1: there is no bypass; the word appears on Out_Data the next cycle.
REQ-029 Clr_Ovf=1 SHALL clear Overflow on the next edge.
REQ-030 Clr_Ovf and a drop event in the same cycle: set wins, and Overflow remains 1.
REQ-031 Full, Empty and Out_Valid SHALL be decoded from registered Count and carry no combinational path from Out_Ready.
REQ-032 Storage contents SHALL NOT be read when Empty; the Out_Data value when Empty is don't-care.

Reset
REQ-033 While RST=1, the block SHALL immediately force: wr_ptr=0, rd_ptr=0, Count=0, Rdy_d=0, Overflow=0.
REQ-034 The forced state SHALL give outputs Empty=1, Full=0, Out_Valid=0.
REQ-035 Storage array contents need not be reset.
REQ-036 Reset asserted mid-operation SHALL discard all stored entries.
REQ-037 If Data_Ready is already high when RST deasserts, that SHALL count as a rising edge, because Rdy_d=0; exactly one push results.
REQ-038 No push or pop SHALL occur on any edge while RST=1.

Verification
REQ-039 Single result:
- Stimulus: after reset, Data_In=13'h0400, IN_N_OUT=0, Data_Ready held high for 4 cycles, Out_Ready=0.
- Required response: Count=1, Out_Valid=1, Out_Data=13'h0400, Out_Mode=0.
REQ-040 Fill and overflow:
- Stimulus: 9 Data_Ready pulses with words 1..9, Out_Ready=0.
- Required response: Count=8, Full=1, Overflow=1; then draining with Out_Ready=1 yields words 1..8 in order, and Empty=1 after the 8th pop.
REQ-041 Full with simultaneous push and pop:
- Stimulus: FIFO full (words 1..8); push word 9 in the same cycle as a pop.
- Required response: Count stays 8, Overflow=0; drain order is 2..9.
REQ-042 Pointer wrap:
- Stimulus: 20 push/pop pairs interleaved with Count between 1 and 3.
- Required response: output sequence equals input sequence, with IN_N_OUT alternating 0/1 and preserved per word.
REQ-043 Clear priority:
- Stimulus: Overflow=1, then Clr_Ovf=1 alone.
- Required response: Overflow=0 on the next edge.
- Stimulus: Clr_Ovf=1 coincident with a drop.
- Required response: Overflow=1.
REQ-044 Reset mid-operation:
- Stimulus: RST pulsed high for 1 ns mid-cycle with Count=5.
- Required response: Count=0, Empty=1, Out_Valid=0 immediately, before the next clock edge.
